// File: rtl/sevenseg_display.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A free-running counter picks the digit; anodes and segments are registered.
module sevenseg_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] display_0,
    input  logic [7:0] display_1,
    input  logic [7:0] display_2,
    input  logic [7:0] display_3,
    input  logic [1:0] decplace,
    output logic [7:0] seg,
    output logic [3:0] an
);

    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic [3:0]              digit;
    logic [6:0]              glyph;

    // Upper nibbles of the digit inputs carry no meaning for the display.
    logic unused_upper;
    assign unused_upper = ^{display_0[7:4], display_1[7:4], display_2[7:4], display_3[7:4]};

    assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        digit = display_0[3:0];
        case (sel)
            2'd0: digit = display_0[3:0];
            2'd1: digit = display_1[3:0];
            2'd2: digit = display_2[3:0];
            2'd3: digit = display_3[3:0];
            default: digit = display_0[3:0];
        endcase
    end

    // Active-low, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        glyph = 7'b1111111;
        case (digit)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            refresh_cnt <= '0;
            an          <= 4'b1111;
            seg         <= 8'hFF;
        end else begin
            refresh_cnt <= refresh_cnt + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            an          <= ~(4'b0001 << sel);
            seg         <= {(sel != decplace), glyph};
        end
    end

endmodule

// File: tb/tb_sevenseg_display.sv
// Directed bench for sevenseg_display with a short refresh counter (4 cycles per digit).
module tb_sevenseg_display;

    logic       clk;
    logic       rstn;
    logic [7:0] display_0, display_1, display_2, display_3;
    logic [1:0] decplace;
    logic [7:0] seg;
    logic [3:0] an;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0] glyph_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] an_tbl  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] scan_seg[4] = '{8'hF9, 8'hA4, 8'h30, 8'h99};

    sevenseg_display #(.REFRESH_BITS(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .display_0 (display_0),
        .display_1 (display_1),
        .display_2 (display_2),
        .display_3 (display_3),
        .decplace  (decplace),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle on the falling edge where inputs change and outputs are read.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic hold_reset();
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(3);
        n_cmp++;
        if (an !== 4'b1111) begin n_err++; $display("FAIL reset_an: got %b want 1111", an); end
        n_cmp++;
        if (seg !== 8'hFF) begin n_err++; $display("FAIL reset_seg: got %h want FF", seg); end
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (an !== 4'b1110) begin n_err++; $display("FAIL reset_release_an: got %b want 1110", an); end
    endtask

    task automatic test_decode();
        decplace = 2'd3;
        for (int v = 0; v < 16; v++) begin
            display_0 = 8'(v);
            hold_reset();
            tick();
            n_cmp++;
            if (an !== 4'b1110) begin n_err++; $display("FAIL decode_an[%0d]: got %b want 1110", v, an); end
            n_cmp++;
            if (seg !== {1'b1, glyph_tbl[v]}) begin
                n_err++;
                $display("FAIL decode_seg[%0d]: got %b want %b", v, seg, {1'b1, glyph_tbl[v]});
            end
        end
    endtask

    task automatic test_scan();
        display_0 = 8'h01; display_1 = 8'h02; display_2 = 8'h03; display_3 = 8'h04;
        decplace  = 2'b10;
        hold_reset();
        for (int i = 0; i < 20; i++) begin
            int d;
            tick();
            d = (i / 4) % 4;
            n_cmp++;
            if (an !== an_tbl[d]) begin n_err++; $display("FAIL scan_an[cyc %0d]: got %b want %b", i, an, an_tbl[d]); end
            n_cmp++;
            if (seg !== scan_seg[d]) begin n_err++; $display("FAIL scan_seg[cyc %0d]: got %h want %h", i, seg, scan_seg[d]); end
        end
    endtask

    task automatic test_upper_nibble();
        display_1 = 8'hA5;
        decplace  = 2'd0;
        hold_reset();
        tick(5);
        n_cmp++;
        if (an !== 4'b1101) begin n_err++; $display("FAIL nibble_an: got %b want 1101", an); end
        n_cmp++;
        if (seg !== 8'b1_0010010) begin n_err++; $display("FAIL nibble_seg: got %b want 10010010", seg); end
    endtask

    task automatic test_live_update();
        display_0 = 8'h00;
        decplace  = 2'd3;
        hold_reset();
        tick();
        n_cmp++;
        if (seg !== 8'b1_1000000) begin n_err++; $display("FAIL live_before: got %b want 11000000", seg); end
        display_0 = 8'h0E;
        tick();
        n_cmp++;
        if (an !== 4'b1110) begin n_err++; $display("FAIL live_an: got %b want 1110", an); end
        n_cmp++;
        if (seg !== 8'b1_0000110) begin n_err++; $display("FAIL live_after: got %b want 10000110", seg); end
    endtask

    task automatic test_reset_mid_scan();
        display_0 = 8'h01; display_1 = 8'h02; display_2 = 8'h03; display_3 = 8'h04;
        decplace  = 2'b10;
        hold_reset();
        tick(13);
        n_cmp++;
        if (an !== 4'b0111) begin n_err++; $display("FAIL midrst_pre_an: got %b want 0111", an); end
        rstn = 1'b0;
        tick();
        n_cmp++;
        if (an !== 4'b1111) begin n_err++; $display("FAIL midrst_an: got %b want 1111", an); end
        n_cmp++;
        if (seg !== 8'hFF) begin n_err++; $display("FAIL midrst_seg: got %h want FF", seg); end
        rstn = 1'b1;
        tick();
        n_cmp++;
        if (an !== 4'b1110) begin n_err++; $display("FAIL midrst_resume_an: got %b want 1110", an); end
        n_cmp++;
        if (seg !== 8'hF9) begin n_err++; $display("FAIL midrst_resume_seg: got %h want F9", seg); end
        tick(4);
        n_cmp++;
        if (an !== 4'b1101) begin n_err++; $display("FAIL midrst_next_an: got %b want 1101", an); end
    endtask

    initial begin
        rstn      = 1'b0;
        display_0 = 8'h00; display_1 = 8'h00; display_2 = 8'h00; display_3 = 8'h00;
        decplace  = 2'd0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_scan();
        test_upper_nibble();
        test_live_update();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
